mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_arb_rr2.sv | 14 +
 rtl/mem_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
    } bus_req_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus bundle of the arbiter.
interface mem_arbiter_if;

    logic        m0_valid;
    logic [15:0] m0_addr;
    logic [15:0] m0_wdata;
    logic [1:0]  m0_wstrb;
    logic        m0_ready;
    logic [15:0] m0_rdata;
    logic        m0_err;

    logic        m1_valid;
    logic [15:0] m1_addr;
    logic [15:0] m1_wdata;
    logic [1:0]  m1_wstrb;
    logic        m1_ready;
    logic [15:0] m1_rdata;
    logic        m1_err;

    logic        s_valid;
    logic [15:0] s_addr;
    logic [15:0] s_wdata;
    logic [1:0]  s_wstrb;
    logic        s_ready;
    logic [15:0] s_rdata;

    // The arbiter itself: serves both requesters and masters the shared memory.
    modport master (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata, m0_err,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata, m1_err,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    modport slave (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata, m0_err,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata, m1_err,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a conflict goes to the one not served last.
module arb_rr2 (
    input  logic [1:0] valid,
    input  logic       lst,
    output logic       any,
    output logic       grant
);

    always_comb begin
        any   = |valid;
        grant = (valid == 2'b11) ? ~lst : valid[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one shared memory port, with a per-transfer timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        g, g_nxt;
    logic        lst, lst_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        pick_any, pick;
    bus_req_t    req0, req1, req_g;
    logic        done, done_err, active;
    logic [15:0] done_rdata;

    assign req0 = '{addr: bus.m0_addr, wdata: bus.m0_wdata, wstrb: bus.m0_wstrb};
    assign req1 = '{addr: bus.m1_addr, wdata: bus.m1_wdata, wstrb: bus.m1_wstrb};

    arb_rr2 u_arb (
        .valid ({bus.m1_valid, bus.m0_valid}),
        .lst   (lst),
        .any   (pick_any),
        .grant (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= 1'b0;
            lst   <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            lst   <= lst_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A memory response in the timeout cycle still counts as a normal completion.
    always_comb begin
        state_nxt  = state;
        g_nxt      = g;
        lst_nxt    = lst;
        cnt_nxt    = cnt;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    g_nxt     = pick;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.s_ready) begin
                    done       = 1'b1;
                    done_rdata = bus.s_rdata;
                end else if (cnt == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
                if (done) begin
                    lst_nxt   = g;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are held at zero while rst is high so a reset mid-transfer aborts silently.
    always_comb begin
        active        = (state == BUSY) && !rst;
        req_g         = g ? req1 : req0;
        bus.s_valid   = active;
        bus.s_addr    = active ? req_g.addr  : 16'h0000;
        bus.s_wdata   = active ? req_g.wdata : 16'h0000;
        bus.s_wstrb   = active ? req_g.wstrb : 2'b00;
        bus.m0_ready  = active && done && !g;
        bus.m1_ready  = active && done && g;
        bus.m0_rdata  = bus.m0_ready ? done_rdata : 16'h0000;
        bus.m1_rdata  = bus.m1_ready ? done_rdata : 16'h0000;
        bus.m0_err    = bus.m0_ready && done_err;
        bus.m1_err    = bus.m1_ready && done_err;
    end

endmodule
